// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler: bus width, stage bit
// indices and controller state encodings.
package pipe_ctrl_pkg;

   localparam int unsigned HOLD_W = 5;

   localparam int unsigned HOLD_PC     = 0;
   localparam int unsigned HOLD_MEM_WB = 1;
   localparam int unsigned HOLD_EX_MEM = 2;
   localparam int unsigned HOLD_ID_EX  = 3;
   localparam int unsigned HOLD_IF_ID  = 4;

   typedef enum logic [0:0] {
      StRun     = 1'b0,
      StDivWait = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/pipe_wdog.sv
// Wait watchdog: counts consecutive wait cycles and flags expiry on the
// TIMEOUT-th one, clearing itself on expiry, on clr_i or on any idle cycle.
module pipe_wdog #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic             expire_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      expire_o = inc_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT - 1));
      cnt_d    = cnt_q;
      if (clr_i || !inc_i || expire_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES  = 32,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ld_use_i,
   input  logic              jump_i,
   input  logic [31:0]       jump_addr_i,
   input  logic              div_start_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ack_i,
   output logic [HOLD_W-1:0] hold_o,
   output logic [HOLD_W-1:0] flush_o,
   output logic              pc_redirect_o,
   output logic [31:0]       redirect_addr_o,
   output logic              div_busy_o,
   output logic              div_done_o,
   output logic              mem_err_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       flush_events_o
`endif
);

   localparam int unsigned DivW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

   ctrl_state_e      state_q, state_d;
   logic [DivW-1:0]  div_cnt_q, div_cnt_d;
   logic             stall_raw;
   logic             wd_expire;
   logic             stall;
   logic [CNT_W-1:0] wd_cnt;

   assign stall_raw = dmem_req_i && !dmem_ack_i;

   pipe_wdog #(
      .CNT_W  (CNT_W),
      .TIMEOUT(MEM_TIMEOUT)
   ) u_wdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (1'b0),
      .inc_i   (stall_raw),
      .expire_o(wd_expire),
      .cnt_o   (wd_cnt)
   );

   // The expiring cycle is treated as a non-stall cycle so the pipe drains.
   assign stall      = stall_raw && !wd_expire;
   assign mem_err_o  = wd_expire && !rst_i;
   assign div_busy_o = (state_q == StDivWait) && !rst_i;

   always_comb begin
      hold_o          = '0;
      flush_o         = '0;
      pc_redirect_o   = 1'b0;
      redirect_addr_o = '0;
      div_done_o      = 1'b0;
      state_d         = state_q;
      div_cnt_d       = div_cnt_q;
      if (rst_i) begin
         state_d   = StRun;
         div_cnt_d = '0;
      end else if (stall) begin
         hold_o = '1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (div_start_i) begin
                  state_d   = StDivWait;
                  div_cnt_d = DivW'(DIV_CYCLES - 2);
               end
               if (jump_i) begin
                  pc_redirect_o       = 1'b1;
                  redirect_addr_o     = jump_addr_i;
                  flush_o[HOLD_IF_ID] = 1'b1;
                  flush_o[HOLD_ID_EX] = 1'b1;
               end else if (ld_use_i) begin
                  hold_o[HOLD_PC]     = 1'b1;
                  hold_o[HOLD_IF_ID]  = 1'b1;
                  flush_o[HOLD_ID_EX] = 1'b1;
               end
            end
            StDivWait: begin
               if (div_cnt_q == '0) begin
                  div_done_o = 1'b1;
                  state_d    = StRun;
               end else begin
                  hold_o[HOLD_PC]      = 1'b1;
                  hold_o[HOLD_IF_ID]   = 1'b1;
                  hold_o[HOLD_ID_EX]   = 1'b1;
                  flush_o[HOLD_EX_MEM] = 1'b1;
                  div_cnt_d            = div_cnt_q - 1'b1;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StRun;
         div_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, flush_events_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         if (|hold_o)  stall_cycles_q <= stall_cycles_q + 32'd1;
         if (|flush_o) flush_events_q <= flush_events_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_events_o = flush_events_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Collects hazard and wait requests from ID (load-use), EX (taken jump, multi-cycle divide) and MEM (data-memory handshake).
- Drives the per-stage hold bus consumed as clock-enables by PC, if_id, id_ex, ex_mem and mem_wb, plus a per-stage flush bus and the PC redirect.
- Owns the divide-latency counter and the memory-wait watchdog.

Parameters:
- HOLD_W, 5, width of hold/flush buses.
- DIV_CYCLES, 32, EX cycles a divide occupies (must be >=2).
- MEM_TIMEOUT, 255, max consecutive dmem wait cycles before abort (>=1).
- CNT_W, 8, width of the watchdog counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ld_use  in  1  ID load-use hazard
- jump  in  1  EX taken branch/jump
- jump_addr  in  32  EX target
- div_start  in  1  EX issues divide (1-cycle pulse)
- dmem_req  in  1  MEM access outstanding
- dmem_ack  in  1  memory completes access
- hold  out  HOLD_W  stage clock-enable inhibit; [0] PC, [1] mem_wb, [2] ex_mem, [3] id_ex, [4] if_id
- flush  out  HOLD_W  stage bubble insert, same bit mapping
- pc_redirect  out  1  load jump_addr into PC
- redirect_addr  out  32  redirect target
- div_busy  out  1  divide in progress
- div_done  out  1  1-cycle pulse, divide result valid in EX
- mem_err  out  1  1-cycle pulse, watchdog abort

Behaviour:
- hold/flush/pc_redirect/redirect_addr/div_done are combinational from inputs and registered state, effective in the same cycle. Only state, div_cnt and wd_cnt are flops.
- Reset: state=RUN, div_cnt=0, wd_cnt=0. While rst=1, all outputs are 0.
- Priority is highest first: mem stall > divide wait > jump > load-use. Lower-priority requests are ignored, not queued, while a higher one is active. Held stages re-present them.
- Mem stall (dmem_req & ~dmem_ack, any state):
  - hold = 5'b11111, flush = 0.
  - wd_cnt increments each stall cycle.
  - When wd_cnt == MEM_TIMEOUT-1 and still stalled: mem_err = 1 that cycle, hold released that cycle, wd_cnt cleared.
  - wd_cnt clears on any non-stall cycle.
- FSM RUN -> DIV_WAIT on div_start while no mem stall; div_cnt loads DIV_CYCLES-2.
- DIV_WAIT:
  - hold bits [0],[4],[3] = 1; flush[2] = 1 (bubble into MEM).
  - div_busy = 1.
  - div_cnt decrements per cycle, frozen during a mem stall.
- DIV_WAIT at div_cnt == 0 with no mem stall: div_done = 1, holds released that cycle, next state RUN.
- div_start while in DIV_WAIT is ignored.
- Jump (RUN, no stall): pc_redirect = 1, redirect_addr = jump_addr, flush[4] = 1 and flush[3] = 1, hold = 0. Jump overrides a simultaneous ld_use.
- Load-use (RUN, no stall, no jump): hold[0] = 1, hold[4] = 1, flush[3] = 1, for exactly the cycles ld_use is high.
- Idle: hold = 0, flush = 0, pc_redirect = 0, redirect_addr = 0.
- Synchronous rst mid-divide or mid-wait aborts to RUN with counters cleared; no div_done or mem_err is emitted.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both wrapping, cleared by rst.
  - stall_cycles increments each cycle with any hold bit set.
  - flush_events increments each cycle with any flush bit set.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - HOLD_W and the stage bit indices (HOLD_PC, HOLD_MEM_WB, HOLD_EX_MEM, HOLD_ID_EX, HOLD_IF_ID).
  - FSM state encodings (RUN, DIV_WAIT).
- One sub-module, pipe_wdog: the wait watchdog counter with clear/inc/expire, reusable for instruction-fetch waits.

Test Plan:
- ld_use=1 one cycle in RUN -> hold=5'b10001, flush=5'b01000 that cycle; next cycle hold=0.
- jump=1, jump_addr=32'h0000_0100, ld_use=1 together -> pc_redirect=1, redirect_addr=0x100, flush=5'b11000, hold=0.
- div_start pulse, DIV_CYCLES=4 -> div_busy high 3 cycles with hold=5'b11001, flush=5'b00100; div_done on the 3rd cycle; RUN after.
- Mem stall inserted mid-divide for 5 cycles -> hold=5'b11111, div_cnt frozen; div_done arrives 5 cycles later than the unstalled case.
- dmem_req=1, dmem_ack=0 held, MEM_TIMEOUT=8 -> hold all-ones cycles 1-7; mem_err pulse with hold=0 on cycle 8.
- rst asserted in DIV_WAIT -> next cycle state RUN, div_busy=0, no div_done pulse; with PIPE_CTRL_PERF_EN, counters read 0.
